// File: rtl/coproc_result_queue.sv
// Coprocessor result queue: in-order FIFO of results released to the core once their ID commits.
// Optional kill counter output enabled by defining COPROC_RESULT_QUEUE_KILLCNT_EN.
module coproc_result_queue #(
  parameter int X_ID_WIDTH  = 4,
  parameter int X_RFW_WIDTH = 32,
  parameter int DEPTH       = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [X_ID_WIDTH-1:0]  in_id,
  input  logic [X_RFW_WIDTH-1:0] in_data,
  input  logic [4:0]             in_rd,
  input  logic                   in_we,
  input  logic                   in_exc,
  input  logic [5:0]             in_exccode,
  input  logic                   commit_valid,
  input  logic [X_ID_WIDTH-1:0]  commit_id,
  input  logic                   commit_kill,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic [X_ID_WIDTH-1:0]  result_id,
  output logic [X_RFW_WIDTH-1:0] result_data,
  output logic [4:0]             result_rd,
  output logic                   result_we,
  output logic                   result_exc,
`ifdef COPROC_RESULT_QUEUE_KILLCNT_EN
  output logic [7:0]             kill_cnt,
`endif
  output logic [5:0]             result_exccode
);

  localparam int AW  = $clog2(DEPTH);
  localparam int NID = 1 << X_ID_WIDTH;
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  typedef struct packed {
    logic [X_ID_WIDTH-1:0]  id;
    logic [X_RFW_WIDTH-1:0] data;
    logic [4:0]             rd;
    logic                   we;
    logic                   exc;
    logic [5:0]             exccode;
  } entry_t;

  entry_t         mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic [NID-1:0] committed;
  logic [NID-1:0] killed;

  entry_t head;
  logic   eligible;
  logic   head_killed;
  logic   push;
  logic   pop;
  logic   silent_pop;

  // Everything the core sees comes from registered state, never from result_ready.
  always_comb begin
    head        = mem[rd_ptr];
    eligible    = (count != '0) && committed[head.id];
    head_killed = killed[head.id];
    in_ready    = (count != FULL);
    push        = in_valid && in_ready;
    silent_pop  = eligible && head_killed;
    pop         = eligible && (head_killed || result_ready);
  end

  always_comb begin
    result_valid   = eligible && !head_killed;
    result_id      = '0;
    result_data    = '0;
    result_rd      = '0;
    result_we      = 1'b0;
    result_exc     = 1'b0;
    result_exccode = '0;
    if (result_valid) begin
      result_id      = head.id;
      result_data    = head.data;
      result_rd      = head.rd;
      result_we      = head.we;
      result_exc     = head.exc;
      result_exccode = head.exccode;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= '{id: in_id, data: in_data, rd: in_rd, we: in_we,
                       exc: in_exc, exccode: in_exccode};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // The commit is applied after the pop clear so a same-cycle set on that ID wins.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      committed <= '0;
      killed    <= '0;
    end else begin
      if (pop) begin
        committed[head.id] <= 1'b0;
        killed[head.id]    <= 1'b0;
      end
      if (commit_valid) begin
        committed[commit_id] <= 1'b1;
        killed[commit_id]    <= commit_kill;
      end
    end
  end

`ifdef COPROC_RESULT_QUEUE_KILLCNT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      kill_cnt <= '0;
    end else if (silent_pop && (kill_cnt != 8'hFF)) begin
      kill_cnt <= kill_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_coproc_result_queue.sv
// Self-checking bench for coproc_result_queue: directed scenarios plus randomized traffic
// compared every cycle against a queue-based reference model.
module tb_coproc_result_queue;

  localparam int IDW   = 4;
  localparam int RFW   = 32;
  localparam int DEPTH = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [IDW-1:0] in_id;
  logic [RFW-1:0] in_data;
  logic [4:0]     in_rd;
  logic           in_we;
  logic           in_exc;
  logic [5:0]     in_exccode;
  logic           commit_valid;
  logic [IDW-1:0] commit_id;
  logic           commit_kill;
  logic           result_valid;
  logic           result_ready;
  logic [IDW-1:0] result_id;
  logic [RFW-1:0] result_data;
  logic [4:0]     result_rd;
  logic           result_we;
  logic           result_exc;
  logic [5:0]     result_exccode;
`ifdef COPROC_RESULT_QUEUE_KILLCNT_EN
  logic [7:0]     kill_cnt;
`endif

  coproc_result_queue #(.X_ID_WIDTH(IDW), .X_RFW_WIDTH(RFW), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_id(in_id), .in_data(in_data),
    .in_rd(in_rd), .in_we(in_we), .in_exc(in_exc), .in_exccode(in_exccode),
    .commit_valid(commit_valid), .commit_id(commit_id), .commit_kill(commit_kill),
    .result_valid(result_valid), .result_ready(result_ready), .result_id(result_id),
    .result_data(result_data), .result_rd(result_rd), .result_we(result_we),
    .result_exc(result_exc),
`ifdef COPROC_RESULT_QUEUE_KILLCNT_EN
    .kill_cnt(kill_cnt),
`endif
    .result_exccode(result_exccode)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of results plus per-ID commit/kill flags.
  typedef struct {
    logic [IDW-1:0] id;
    logic [RFW-1:0] data;
    logic [4:0]     rd;
    logic           we;
    logic           exc;
    logic [5:0]     exccode;
  } ent_t;

  ent_t mq[$];
  bit   mcom [16];
  bit   mkil [16];
  int   mkill = 0;

  always @(posedge clk or posedge rst) begin : model
    bit   do_pop;
    bit   was_killed;
    ent_t h;
    ent_t e;
    if (rst) begin
      mq.delete();
      for (int i = 0; i < 16; i++) begin
        mcom[i] = 1'b0;
        mkil[i] = 1'b0;
      end
      mkill = 0;
    end else begin
      do_pop     = 1'b0;
      was_killed = 1'b0;
      if (mq.size() != 0) begin
        h = mq[0];
        if (mcom[h.id]) begin
          was_killed = mkil[h.id];
          do_pop     = was_killed || result_ready;
        end
      end
      if (do_pop) begin
        void'(mq.pop_front());
        mcom[h.id] = 1'b0;
        mkil[h.id] = 1'b0;
        if (was_killed && mkill < 255) mkill++;
      end
      if (in_valid && (mq.size() + (do_pop ? 1 : 0)) != DEPTH) begin
        e.id = in_id; e.data = in_data; e.rd = in_rd;
        e.we = in_we; e.exc = in_exc; e.exccode = in_exccode;
        mq.push_back(e);
      end
      if (commit_valid) begin
        mcom[commit_id] = 1'b1;
        mkil[commit_id] = commit_kill;
      end
    end
  end

  always @(negedge clk) begin : compare
    bit   ev;
    ent_t h;
    if (!rst) begin
      ev = 1'b0;
      h  = '{default: '0};
      if (mq.size() != 0) begin
        if (mcom[mq[0].id] && !mkil[mq[0].id]) begin
          ev = 1'b1;
          h  = mq[0];
        end
      end
      checkOutput("in_ready", 64'(in_ready), 64'(mq.size() != DEPTH));
      checkOutput("result_valid", 64'(result_valid), 64'(ev));
      checkOutput("result_id", 64'(result_id), 64'(h.id));
      checkOutput("result_data", 64'(result_data), 64'(h.data));
      checkOutput("result_rd", 64'(result_rd), 64'(h.rd));
      checkOutput("result_we", 64'(result_we), 64'(h.we));
      checkOutput("result_exc", 64'(result_exc), 64'(h.exc));
      checkOutput("result_exccode", 64'(result_exccode), 64'(h.exccode));
`ifdef COPROC_RESULT_QUEUE_KILLCNT_EN
      checkOutput("kill_cnt", 64'(kill_cnt), 64'(mkill));
`endif
    end
  end

  task automatic applyStimulus(input bit pv, input logic [IDW-1:0] pid, input logic [RFW-1:0] pd,
                               input logic [4:0] prd, input bit cv, input logic [IDW-1:0] cid,
                               input bit ck, input bit rr);
    in_valid     = pv;
    in_id        = pid;
    in_data      = pd;
    in_rd        = prd;
    in_we        = pv;
    in_exc       = 1'b0;
    in_exccode   = pv ? {1'b0, prd} : 6'd0;
    commit_valid = cv;
    commit_id    = cid;
    commit_kill  = ck;
    result_ready = rr;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input bit rr);
    applyStimulus(1'b0, '0, '0, '0, 1'b0, '0, 1'b0, rr);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 0; in_id = 0; in_data = 0; in_rd = 0; in_we = 0; in_exc = 0; in_exccode = 0;
    commit_valid = 0; commit_id = 0; commit_kill = 0; result_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_valid", 64'(result_valid), 64'd0);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset_data", 64'(result_data), 64'd0);
    rst = 1'b0;

    // Commit first, then the result shows up one cycle after its push.
    applyStimulus(0, 0, 0, 0, 1, 4'd3, 0, 1);
    checkOutput("cf_valid_before", 64'(result_valid), 64'd0);
    applyStimulus(1, 4'd3, 32'hDEADBEEF, 5'd5, 0, 0, 0, 1);
    checkOutput("cf_valid", 64'(result_valid), 64'd1);
    checkOutput("cf_id", 64'(result_id), 64'd3);
    checkOutput("cf_data", 64'(result_data), 64'hDEADBEEF);
    checkOutput("cf_rd", 64'(result_rd), 64'd5);
    idle(1);
    checkOutput("cf_drained", 64'(result_valid), 64'd0);

    // Result first, commit later, with backpressure.
    applyStimulus(1, 4'd1, 32'h11, 5'd1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("rf_wait", 64'(result_valid), 64'd0);
      idle(0);
    end
    applyStimulus(0, 0, 0, 0, 1, 4'd1, 0, 0);
    checkOutput("rf_valid", 64'(result_valid), 64'd1);
    checkOutput("rf_id", 64'(result_id), 64'd1);
    for (int i = 0; i < 2; i++) begin
      idle(0);
      checkOutput("rf_hold_valid", 64'(result_valid), 64'd1);
      checkOutput("rf_hold_data", 64'(result_data), 64'h11);
    end
    idle(1);
    checkOutput("rf_empty_valid", 64'(result_valid), 64'd0);
    checkOutput("rf_empty_ready", 64'(in_ready), 64'd1);

    // Killed head is dropped silently; the next one is emitted.
    applyStimulus(1, 4'd2, 32'h22, 5'd2, 0, 0, 0, 1);
    applyStimulus(1, 4'd4, 32'h44, 5'd4, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1, 4'd2, 1, 1);
    checkOutput("kill_hidden", 64'(result_valid), 64'd0);
    applyStimulus(0, 0, 0, 0, 1, 4'd4, 0, 1);
    checkOutput("kill_next_valid", 64'(result_valid), 64'd1);
    checkOutput("kill_next_id", 64'(result_id), 64'd4);
`ifdef COPROC_RESULT_QUEUE_KILLCNT_EN
    checkOutput("kill_cnt_one", 64'(kill_cnt), 64'd1);
`endif
    idle(1);
    checkOutput("kill_drained", 64'(result_valid), 64'd0);

    // Fill, reject an extra push, then drain and wrap the pointers.
    for (int i = 8; i < 12; i++) applyStimulus(1, IDW'(i), RFW'(i), 5'(i), 0, 0, 0, 1);
    checkOutput("full_ready", 64'(in_ready), 64'd0);
    applyStimulus(1, 4'd12, 32'hC, 5'd12, 1, 4'd8, 0, 1);
    checkOutput("full_head_valid", 64'(result_valid), 64'd1);
    checkOutput("full_head_id", 64'(result_id), 64'd8);
    checkOutput("full_still", 64'(in_ready), 64'd0);
    idle(1);
    checkOutput("full_pop_ready", 64'(in_ready), 64'd1);
    for (int i = 9; i < 12; i++) applyStimulus(0, 0, 0, 0, 1, IDW'(i), 0, 1);
    idle(1);
    checkOutput("full_drained", 64'(result_valid), 64'd0);
    for (int i = 0; i < 10; i++) applyStimulus(1, IDW'(i), RFW'(32'h100 + i), 5'(i), 1, IDW'(i), 0, 1);
    repeat (3) idle(1);

    // Strict in-order drain despite out-of-order commits.
    applyStimulus(1, 4'd0, 32'hA0, 5'd10, 0, 0, 0, 1);
    applyStimulus(1, 4'd1, 32'hA1, 5'd11, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1, 4'd1, 0, 1);
    checkOutput("order_blocked", 64'(result_valid), 64'd0);
    idle(1);
    checkOutput("order_blocked2", 64'(result_valid), 64'd0);
    applyStimulus(0, 0, 0, 0, 1, 4'd0, 0, 1);
    checkOutput("order_first", 64'(result_id), 64'd0);
    checkOutput("order_first_data", 64'(result_data), 64'hA0);
    idle(1);
    checkOutput("order_second", 64'(result_id), 64'd1);
    checkOutput("order_second_v", 64'(result_valid), 64'd1);
    idle(1);
    checkOutput("order_empty", 64'(result_valid), 64'd0);

    // Asynchronous reset while entries are queued and committed.
    applyStimulus(1, 4'd5, 32'h55, 5'd5, 1, 4'd5, 0, 0);
    applyStimulus(1, 4'd6, 32'h66, 5'd6, 1, 4'd6, 0, 0);
    applyStimulus(1, 4'd7, 32'h77, 5'd7, 1, 4'd7, 0, 0);
    checkOutput("rst_pre_valid", 64'(result_valid), 64'd1);
    in_valid = 1'b0;
    commit_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_async_valid", 64'(result_valid), 64'd0);
    checkOutput("rst_async_ready", 64'(in_ready), 64'd1);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      checkOutput("rst_no_stale", 64'(result_valid), 64'd0);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      in_valid     = ($urandom % 2) == 0;
      in_id        = IDW'($urandom);
      in_data      = $urandom;
      in_rd        = 5'($urandom);
      in_we        = 1'($urandom);
      in_exc       = ($urandom % 8) == 0;
      in_exccode   = 6'($urandom);
      commit_valid = ($urandom % 3) == 0;
      commit_id    = IDW'($urandom);
      commit_kill  = ($urandom % 4) == 0;
      result_ready = ($urandom % 4) != 0;
      @(posedge clk);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
